ddr3_cmd_gen: RTL
=================

Name: ddr3_cmd_gen

Overview:
- Command generator downstream of the refresh FSM and the bank FSMs.
- Arbitrates refresh requests against bank commands, with refresh having absolute priority.
- Enforces a conservative minimum-spacing guard after each issued command.
- Drives registered DDR3 command pins (cs_n/ras_n/cas_n/we_n/ba/addr) to the PHY.

Parameters:
- BANK_W, 3, bank address width
- ADDR_W, 14, DDR3 address bus width (row width; columns zero-extended)
- COL_W, 10, column address width, must be ≤ ADDR_W-1
- T_RCD, tRCD_CYCLES, cycles from ACTIVATE to next command
- T_RP, tRP_CYCLES, cycles from PRECHARGE to next command
- T_CCD, tCCD_CYCLES, cycles from READ/WRITE to next command
- T_RFC, tRFC_CYCLES, cycles from REFRESH to next command

Ports:
- clk  in  1  controller clock
- rst  in  1  synchronous active-high reset
- refresh_cmd_valid  in  1  single-cycle refresh request strobe from refresh FSM
- refresh_req  in  ddr3_cmd_t  command accompanying the strobe (CMD_REFRESH expected)
- bank_cmd_valid  in  1  bank FSM command valid
- bank_cmd  in  ddr3_cmd_t  ACTIVATE/READ/WRITE/PRECHARGE/NOP
- bank_ba  in  BANK_W  target bank
- bank_row  in  ADDR_W  row (ACTIVATE)
- bank_col  in  COL_W  column (READ/WRITE)
- bank_cmd_ready  out  1  bank command accepted this cycle when high with valid
- refresh_ack  out  1  one-cycle pulse, the cycle REFRESH appears on the pins
- ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n  out  1 each  DDR3 command pins
- ddr_ba  out  BANK_W  bank address pins
- ddr_addr  out  ADDR_W  address pins

Behaviour:
- Clock and reset: single clk domain. rst is synchronous and active-high; it clears all state at the next rising edge.
- Reset values: cs_n=1, ras_n=1, cas_n=1, we_n=1, ba=0, addr=0, refresh_ack=0, guard=0, ref_pending=0.
- Pin encoding (cs,ras,cas,we), all registered:
  - NOP 0111
  - ACTIVATE 0011, addr=row
  - READ 0101, addr=col, A10=0
  - WRITE 0100, addr=col, A10=0
  - PRECHARGE 0010, A10=1 (all banks), ba=bank_ba
  - REFRESH 0001, addr=0, ba=0
- Idle cycles drive NOP (cs_n=0).
- Latency: a command accepted in cycle N appears on the pins in cycle N+1.
- State machine:
  - READY: guard==0. An issue is allowed this cycle.
  - GUARD: guard>0. Decrement by 1 each cycle. Go to READY when guard reaches 0. No command issues while in GUARD.
- Guard load on issue (value loaded = delay-1):
  - ACT → T_RCD-1
  - RD/WR → T_CCD-1
  - PRE → T_RP-1
  - REF → T_RFC-1
  - NOP → no load
- Refresh handling:
  - refresh_cmd_valid is never dropped. It sets ref_pending if it cannot issue the same cycle.
  - A refresh issues when READY and (refresh_cmd_valid or ref_pending). ref_pending clears on issue.
- bank_cmd_ready = READY & !ref_pending & !refresh_cmd_valid & !rst.
- Simultaneous refresh and bank request: refresh wins. The bank request holds (valid stays high, ready low) and issues on the first READY cycle after the REFRESH guard expires.
- bank_cmd=NOP with valid: accepted, drives NOP, no guard load.
- refresh_req other than CMD_REFRESH with a valid strobe: treated as REFRESH (logged as an assertion error).
- Guard counter: 6 bits, saturating at 0. All T_* parameters must be ≥1 and ≤64.
- Reset mid-guard or with a pending refresh: the pending refresh is discarded and pins return to deselect (cs_n=1).

Optional Feature:
- Macro: DDR3_CMD_STATS_EN.
- When defined: adds outputs stat_ref_count[15:0] and stat_cmd_count[15:0].
  - stat_ref_count increments per issued REFRESH.
  - stat_cmd_count increments per issued non-NOP command.
  - Both wrap at 0xFFFF→0 and reset to 0.
- When undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package ddr3_pkg:
  - extend ddr3_cmd_t with CMD_ACTIVATE, CMD_READ, CMD_WRITE, CMD_PRECHARGE
  - add tRCD_CYCLES, tRP_CYCLES, tCCD_CYCLES
  - add a cmd_pins_t struct {cs_n, ras_n, cas_n, we_n}
  - tRFC_CYCLES already lives there
- One sub-module, ddr3_cmd_guard_timer: load/decrement/zero-flag counter, instantiated once.

Test Plan:
- Reset, then idle: pins NOP 0111, refresh_ack=0, bank_cmd_ready=1 from the first post-reset cycle. During rst: cs_n=1.
- ACTIVATE bank 2 row 0x1234, then READ col 0x05 held valid, T_RCD=6: ACT on the pins at N+1 with ba=2, addr=0x1234. READ ready stays low 5 cycles. READ on the pins at N+7 with addr=0x005, A10=0.
- PRECHARGE issued, refresh strobe 2 cycles later, T_RP=6: ref_pending set. REFRESH appears exactly 6 cycles after PRE with refresh_ack pulsed once. Next command blocked for T_RFC.
- refresh_cmd_valid and bank ACT in the same cycle: REFRESH issues at N+1. ACT issues the cycle the REFRESH guard expires, with no command lost.
- Assert rst while guard=4 and ref_pending=1: at the next edge pins are deselect and guard=0. No REFRESH issues after rst is released.
- With DDR3_CMD_STATS_EN defined, 3 refreshes and 5 bank commands: stat_ref_count=3, stat_cmd_count=8. Preload stat_ref_count to 0xFFFF, one more refresh → 0.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared DDR3 controller types: command enum, timing defaults, pin struct.
package ddr3_pkg;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_REFRESH   = 3'd1,
    CMD_ACTIVATE  = 3'd2,
    CMD_READ      = 3'd3,
    CMD_WRITE     = 3'd4,
    CMD_PRECHARGE = 3'd5
  } ddr3_cmd_t;

  localparam int unsigned tRFC_CYCLES = 10;
  localparam int unsigned tRCD_CYCLES = 6;
  localparam int unsigned tRP_CYCLES  = 6;
  localparam int unsigned tCCD_CYCLES = 4;

  localparam int unsigned GUARD_W = 6;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } cmd_pins_t;

  typedef enum logic {
    ST_READY,
    ST_GUARD
  } guard_state_t;

  localparam cmd_pins_t PINS_DESELECT = '1;

  function automatic cmd_pins_t cmd_to_pins(input ddr3_cmd_t c);
    case (c)
      CMD_ACTIVATE:  return 4'b0011;
      CMD_READ:      return 4'b0101;
      CMD_WRITE:     return 4'b0100;
      CMD_PRECHARGE: return 4'b0010;
      CMD_REFRESH:   return 4'b0001;
      default:       return 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/ddr3_cmd_guard_timer.sv
// Minimum-spacing guard counter: loads on issue, counts down to zero and holds.
module ddr3_cmd_guard_timer
  import ddr3_pkg::*;
#(
  parameter int unsigned W = GUARD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/ddr3_cmd_gen.sv
// DDR3 command generator: refresh-priority arbitration, spacing guard, registered pins.
// Optional DDR3_CMD_STATS_EN adds stat_ref_count / stat_cmd_count outputs.
module ddr3_cmd_gen
  import ddr3_pkg::*;
#(
  parameter int unsigned BANK_W = 3,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned T_RCD  = tRCD_CYCLES,
  parameter int unsigned T_RP   = tRP_CYCLES,
  parameter int unsigned T_CCD  = tCCD_CYCLES,
  parameter int unsigned T_RFC  = tRFC_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              refresh_cmd_valid,
  input  ddr3_cmd_t         refresh_req,
  input  logic              bank_cmd_valid,
  input  ddr3_cmd_t         bank_cmd,
  input  logic [BANK_W-1:0] bank_ba,
  input  logic [ADDR_W-1:0] bank_row,
  input  logic [COL_W-1:0]  bank_col,
  output logic              bank_cmd_ready,
  output logic              refresh_ack,
  output logic              ddr_cs_n,
  output logic              ddr_ras_n,
  output logic              ddr_cas_n,
  output logic              ddr_we_n,
  output logic [BANK_W-1:0] ddr_ba,
  output logic [ADDR_W-1:0] ddr_addr
`ifdef DDR3_CMD_STATS_EN
  ,
  output logic [15:0]       stat_ref_count,
  output logic [15:0]       stat_cmd_count
`endif
);

  if (T_RCD < 1 || T_RCD > 64 || T_RP < 1 || T_RP > 64 ||
      T_CCD < 1 || T_CCD > 64 || T_RFC < 1 || T_RFC > 64) begin : g_bad_timing
    $error("ddr3_cmd_gen: T_* parameters must lie in 1..64");
  end

  localparam logic [GUARD_W-1:0] LD_RCD = GUARD_W'(T_RCD - 1);
  localparam logic [GUARD_W-1:0] LD_RP  = GUARD_W'(T_RP - 1);
  localparam logic [GUARD_W-1:0] LD_CCD = GUARD_W'(T_CCD - 1);
  localparam logic [GUARD_W-1:0] LD_RFC = GUARD_W'(T_RFC - 1);

  logic               w_zero;
  guard_state_t       w_state;
  logic               w_issue_ref;
  logic               w_issue_bank;
  logic               w_load;
  logic [GUARD_W-1:0] w_load_val;
  logic               w_cmd_issued;
  cmd_pins_t          w_pins;
  logic [BANK_W-1:0]  w_ba;
  logic [ADDR_W-1:0]  w_addr;

  cmd_pins_t          r_pins;
  logic [BANK_W-1:0]  r_ba;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_ack;
  logic               r_ref_pending;

  ddr3_cmd_guard_timer #(.W(GUARD_W)) u_guard (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // The guard counter itself is the state register; READY simply means it has drained.
  assign w_state        = w_zero ? ST_READY : ST_GUARD;
  assign w_issue_ref    = (w_state == ST_READY) & (refresh_cmd_valid | r_ref_pending) & ~rst;
  assign bank_cmd_ready = (w_state == ST_READY) & ~r_ref_pending & ~refresh_cmd_valid & ~rst;
  assign w_issue_bank   = bank_cmd_ready & bank_cmd_valid;

  always_comb begin
    w_pins       = cmd_to_pins(CMD_NOP);
    w_ba         = '0;
    w_addr       = '0;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_cmd_issued = 1'b0;
    if (w_issue_ref) begin
      w_pins       = cmd_to_pins(CMD_REFRESH);
      w_load       = 1'b1;
      w_load_val   = LD_RFC;
      w_cmd_issued = 1'b1;
    end else if (w_issue_bank) begin
      case (bank_cmd)
        CMD_ACTIVATE: begin
          w_pins       = cmd_to_pins(CMD_ACTIVATE);
          w_ba         = bank_ba;
          w_addr       = bank_row;
          w_load       = 1'b1;
          w_load_val   = LD_RCD;
          w_cmd_issued = 1'b1;
        end
        CMD_READ, CMD_WRITE: begin
          w_pins       = cmd_to_pins(bank_cmd);
          w_ba         = bank_ba;
          w_addr       = ADDR_W'(bank_col);
          w_addr[10]   = 1'b0;
          w_load       = 1'b1;
          w_load_val   = LD_CCD;
          w_cmd_issued = 1'b1;
        end
        CMD_PRECHARGE: begin
          w_pins       = cmd_to_pins(CMD_PRECHARGE);
          w_ba         = bank_ba;
          w_addr[10]   = 1'b1;
          w_load       = 1'b1;
          w_load_val   = LD_RP;
          w_cmd_issued = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pins        <= PINS_DESELECT;
      r_ba          <= '0;
      r_addr        <= '0;
      r_ack         <= 1'b0;
      r_ref_pending <= 1'b0;
    end else begin
      r_pins <= w_pins;
      r_ba   <= w_ba;
      r_addr <= w_addr;
      r_ack  <= w_issue_ref;
      if (w_issue_ref)            r_ref_pending <= 1'b0;
      else if (refresh_cmd_valid) r_ref_pending <= 1'b1;
    end
  end

  assign ddr_cs_n    = r_pins.cs_n;
  assign ddr_ras_n   = r_pins.ras_n;
  assign ddr_cas_n   = r_pins.cas_n;
  assign ddr_we_n    = r_pins.we_n;
  assign ddr_ba      = r_ba;
  assign ddr_addr    = r_addr;
  assign refresh_ack = r_ack;

`ifdef DDR3_CMD_STATS_EN
  logic [15:0] r_ref_count;
  logic [15:0] r_cmd_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_count <= '0;
      r_cmd_count <= '0;
    end else begin
      if (w_issue_ref)  r_ref_count <= r_ref_count + 16'd1;
      if (w_cmd_issued) r_cmd_count <= r_cmd_count + 16'd1;
    end
  end

  assign stat_ref_count = r_ref_count;
  assign stat_cmd_count = r_cmd_count;
`endif

  a_refresh_req_kind: assert property (@(posedge clk) disable iff (rst)
    refresh_cmd_valid |-> refresh_req == CMD_REFRESH);

endmodule
